// File: rtl/matrix_stream_host.sv
// matrix_stream_host: packs streamed A/B words onto the matrix engine operand buses and streams the C result back out
module matrix_stream_host #(
    parameter int NUM_FIRST_ROW  = 2,
    parameter int NUM_FIRST_COL  = 2,
    parameter int NUM_SECOND_COL = 2
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic [31:0]                                in_data,
    input  logic                                       in_stb,
    output logic                                       in_ack,
    output logic [32*NUM_FIRST_ROW*NUM_FIRST_COL-1:0]  mat_in1,
    output logic [32*NUM_FIRST_COL*NUM_SECOND_COL-1:0] mat_in2,
    output logic                                       load,
    input  logic [32*NUM_FIRST_ROW*NUM_SECOND_COL-1:0] mat_out,
    input  logic                                       mat_out_ready,
    output logic                                       mat_out_ack,
    output logic [31:0]                                out_data,
    output logic                                       out_stb,
    input  logic                                       out_ack
);
    localparam int NA = NUM_FIRST_ROW * NUM_FIRST_COL;
    localparam int NB = NUM_FIRST_COL * NUM_SECOND_COL;
    localparam int NC = NUM_FIRST_ROW * NUM_SECOND_COL;
    localparam int NM = NA > NB ? (NA > NC ? NA : NC) : (NB > NC ? NB : NC);
    localparam int IW = NM > 1 ? $clog2(NM) : 1;
    typedef enum logic [2:0] {COLLECT_A, COLLECT_B, LAUNCH, WAIT_LOW, WAIT_RESULT, EMIT} state_t;
    state_t state, state_nx;
    logic [IW-1:0] idx;
    logic [32*NC-1:0] c_reg;
    logic xfer_in, xfer_out;
    assign in_ack      = rst && (state == COLLECT_A || state == COLLECT_B);
    assign load        = state == LAUNCH;
    assign mat_out_ack = state == WAIT_RESULT && mat_out_ready;
    assign out_stb     = state == EMIT;
    assign out_data    = out_stb ? c_reg[32*(NC-1-int'(idx)) +: 32] : '0;
    assign xfer_in     = in_stb && in_ack;
    assign xfer_out    = out_stb && out_ack;
    always_comb begin
        state_nx = state;
        case (state)
            COLLECT_A:   if (xfer_in && idx == IW'(NA-1)) state_nx = COLLECT_B;
            COLLECT_B:   if (xfer_in && idx == IW'(NB-1)) state_nx = LAUNCH;
            LAUNCH:      state_nx = WAIT_LOW;
            WAIT_LOW:    if (!mat_out_ready) state_nx = WAIT_RESULT;
            WAIT_RESULT: if (mat_out_ready) state_nx = EMIT;
            EMIT:        if (xfer_out && idx == IW'(NC-1)) state_nx = COLLECT_A;
            default:     state_nx = COLLECT_A;
        endcase
    end
    // element index e sits at the MSB end of each bus: bits [W-1-32e -: 32]
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= COLLECT_A;
            idx     <= '0;
            mat_in1 <= '0;
            mat_in2 <= '0;
            c_reg   <= '0;
        end else begin
            state <= state_nx;
            idx   <= state_nx != state ? '0 : idx + IW'(xfer_in || xfer_out);
            if (xfer_in && state == COLLECT_A) mat_in1[32*(NA-1-int'(idx)) +: 32] <= in_data;
            if (xfer_in && state == COLLECT_B) mat_in2[32*(NB-1-int'(idx)) +: 32] <= in_data;
            if (mat_out_ack) c_reg <= mat_out;
        end
    end
endmodule
